// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the parametrised instruction memory:
//   - opcode and register codes of the 16-bit instruction encoding
//   - boot sequencer state encoding (INIT / IDLE)
//   - boot_word(): the default program image written after reset or on a
//     soft re-init request
// Optional feature macro used elsewhere in this slice: IMEM_PARITY_EN.
// ---------------------------------------------------------------------------
package imem_pkg;

  // Opcodes live in instruction bits [15:13].
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;

  // Register codes (3-bit fields).
  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;

  // Width of one boot-image word before it is fitted to DATA_W.
  localparam int BOOT_WORD_W = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } boot_state_t;

  // Default program image. Anything past the listed words is a NOP (0).
  function automatic logic [BOOT_WORD_W-1:0] boot_word(input int unsigned addr);
    logic [BOOT_WORD_W-1:0] w;
    case (addr)
      0:       w = 16'hA081;  // ST  R0,R1,#1
      1:       w = 16'h8882;  // LD  R2,R1,#2
      2:       w = 16'h40A0;  // ADD R0,R1,R2
      3:       w = 16'h60A2;  // SUB R0,R1,R2,#2
      4:       w = 16'h6000;  // SUB R0,R0,R0
      5:       w = 16'h40A0;  // ADD R0,R1,R2
      6:       w = 16'h40A0;  // ADD R0,R1,R2
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memoria_instrucoes_param_if.sv
// ---------------------------------------------------------------------------
// memoria_instrucoes_param_if
// Bus bundle between the fetch stage / program loader (master) and the
// instruction memory (slave).
//   Init_req  master->slave  soft re-boot request (one-cycle pulse)
//   Busy      slave->master  boot sequencer running
//   Rd_en, Rd_addr           fetch request and address
//   Q, Q_valid               fetched word and its one-cycle valid pulse
//   Wren, Wr_addr, Din       load port
//   Par_err                  parity error flag aligned with Q_valid
//   Flip_par                 parity error injection (only with IMEM_PARITY_EN)
// ---------------------------------------------------------------------------
interface memoria_instrucoes_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              Init_req;
  logic              Busy;
  logic              Rd_en;
  logic [ADDR_W-1:0] Rd_addr;
  logic [DATA_W-1:0] Q;
  logic              Q_valid;
  logic              Wren;
  logic [ADDR_W-1:0] Wr_addr;
  logic [DATA_W-1:0] Din;
  logic              Par_err;
`ifdef IMEM_PARITY_EN
  logic              Flip_par;

  modport master (
    output Init_req, Rd_en, Rd_addr, Wren, Wr_addr, Din, Flip_par,
    input  Busy, Q, Q_valid, Par_err
  );

  modport slave (
    input  Init_req, Rd_en, Rd_addr, Wren, Wr_addr, Din, Flip_par,
    output Busy, Q, Q_valid, Par_err
  );
`else
  modport master (
    output Init_req, Rd_en, Rd_addr, Wren, Wr_addr, Din,
    input  Busy, Q, Q_valid, Par_err
  );

  modport slave (
    input  Init_req, Rd_en, Rd_addr, Wren, Wr_addr, Din,
    output Busy, Q, Q_valid, Par_err
  );
`endif

endinterface

// File: rtl/imem_boot_seq.sv
// ---------------------------------------------------------------------------
// imem_boot_seq
// Boot sequencer: walks a counter over every memory address after reset or a
// soft re-init request, producing the write strobe and address used to load
// the default program image.
//   Clock     rising-edge clock
//   Reset     asynchronous active-low reset (restarts the sequence at 0)
//   Init_req  re-init request, honoured only in IDLE
//   busy      high while the sequence runs (state INIT)
//   boot_we   write strobe into the array (same as busy)
//   boot_addr address being written this cycle
// ---------------------------------------------------------------------------
module imem_boot_seq
  import imem_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Init_req,
  output logic              busy,
  output logic              boot_we,
  output logic [ADDR_W-1:0] boot_addr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'((2 ** ADDR_W) - 1);

  boot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values; combinational blocks below use blocking.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The last address is written this cycle; hand over on this edge.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (Init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign busy      = (state_q == ST_INIT);
  assign boot_we   = busy;
  assign boot_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/memoria_instrucoes_param.sv
// ---------------------------------------------------------------------------
// memoria_instrucoes_param
// Parametrised instruction memory with a fetch port (1-cycle registered
// read, Q_valid pulse) and a load port. A boot sequencer fills the array with
// the default program image after reset and on a soft re-init request; host
// reads, writes and re-init requests are ignored while it runs.
//   Clock  rising-edge clock
//   Reset  asynchronous active-low reset (array contents are kept)
//   bus    slave side of memoria_instrucoes_param_if (Init_req, Busy, fetch,
//          load and Par_err signals)
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word, enable Flip_par error injection and drive Par_err from the stored
// parity. Without it Par_err is tied low.
// ---------------------------------------------------------------------------
module memoria_instrucoes_param
  import imem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BOOT_LEN = 7
) (
  input logic                      Clock,
  input logic                      Reset,
  memoria_instrucoes_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;  // {parity, data}
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  logic              busy;
  logic              boot_we;
  logic [ADDR_W-1:0] boot_addr;

  imem_boot_seq #(
    .ADDR_W (ADDR_W)
  ) u_boot_seq (
    .Clock     (Clock),
    .Reset     (Reset),
    .Init_req  (bus.Init_req),
    .busy      (busy),
    .boot_we   (boot_we),
    .boot_addr (boot_addr)
  );

  assign bus.Busy = busy;

  // Host accesses only count in IDLE, and a re-init request in the same cycle
  // swallows them.
  logic host_ok;
  assign host_ok = !busy && !bus.Init_req;

  // Boot image word fitted to DATA_W (truncated or zero-extended), with
  // everything at or past BOOT_LEN forced to NOP.
  logic [BOOT_WORD_W-1:0] boot_raw;
  logic [DATA_W-1:0]      boot_data;

  always_comb begin
    boot_raw  = '0;
    boot_data = '0;
    if (32'(boot_addr) < BOOT_LEN) begin
      boot_raw = boot_word(32'(boot_addr));
    end
    for (int i = 0; i < DATA_W && i < BOOT_WORD_W; i++) begin
      boot_data[i] = boot_raw[i];
    end
  end

  // Write-port mux: the boot sequencer owns the array while busy.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword;
  logic              host_wpar;

`ifdef IMEM_PARITY_EN
  assign host_wpar = (^bus.Din) ^ bus.Flip_par;
`else
  assign host_wpar = 1'b0;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wword = '0;
    if (boot_we) begin
      mem_we    = 1'b1;
      mem_waddr = boot_addr;
`ifdef IMEM_PARITY_EN
      mem_wword = {^boot_data, boot_data};
`else
      mem_wword = boot_data;
`endif
    end else if (host_ok && bus.Wren) begin
      mem_we    = 1'b1;
      mem_waddr = bus.Wr_addr;
`ifdef IMEM_PARITY_EN
      mem_wword = {host_wpar, bus.Din};
`else
      mem_wword = bus.Din;
`endif
    end
  end

  // NOTE: the array has no reset; contents survive Reset and are rebuilt by
  // the boot sequencer, which also keeps it mappable to RAM.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Fetch: a same-address write in the same cycle is forwarded (write-through).
  logic             rd_fire;
  logic             wt_hit;
  logic [MEM_W-1:0] rd_word;

  assign rd_fire = host_ok && bus.Rd_en;
  assign wt_hit  = host_ok && bus.Wren && (bus.Wr_addr == bus.Rd_addr);

`ifdef IMEM_PARITY_EN
  assign rd_word = wt_hit ? {host_wpar, bus.Din} : mem[bus.Rd_addr];
`else
  assign rd_word = wt_hit ? bus.Din : mem[bus.Rd_addr];
`endif

  logic [DATA_W-1:0] q_q;
  logic              q_valid_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= rd_fire;
      if (rd_fire) begin
        q_q <= rd_word[DATA_W-1:0];
      end
    end
  end

  assign bus.Q       = q_q;
  assign bus.Q_valid = q_valid_q;

`ifdef IMEM_PARITY_EN
  logic par_err_q;
  logic rd_perr;

  assign rd_perr = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= rd_fire && rd_perr;
    end
  end

  assign bus.Par_err = par_err_q;
`else
  assign bus.Par_err = 1'b0;
  logic unused_host_wpar;
  assign unused_host_wpar = host_wpar;
`endif

endmodule

// File: doc/memoria_instrucoes_param.md
Name: memoria_instrucoes_param

Overview:
- Parametrised instruction memory, the successor to the fixed 16x16 instruction store; sits between the fetch stage and the program loader.
- Depth and width are configurable. Separate fetch (read) and load (write) ports.
- After reset, a multi-cycle boot sequencer writes the default program image; a soft re-init request repeats it.
- Fetch uses a registered valid/busy handshake.

Parameters:
- DATA_W, 16, instruction word width in bits; boot image is truncated or zero-extended to DATA_W.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- BOOT_LEN, 7, number of leading boot-image words that are non-NOP; words at addresses >= BOOT_LEN are 0.

Ports:
- Clock, input, 1, single clock; all state updates on the rising edge.
- Reset, input, 1, asynchronous, active-low reset.
- Init_req, input, 1, one-cycle pulse that requests a soft re-boot (rewrite of the boot image).
- Busy, output, 1, high while the boot sequencer is running.
- Rd_en, input, 1, fetch request.
- Rd_addr, input, ADDR_W, fetch address.
- Q, output, DATA_W, fetched instruction word.
- Q_valid, output, 1, one-cycle pulse marking Q valid.
- Wren, input, 1, load-port write enable.
- Wr_addr, input, ADDR_W, load address.
- Din, input, DATA_W, load data.
- Par_err, output, 1, parity error flag, aligned with Q_valid (see Optional Feature).

Behaviour:
- Reset low (asynchronous): Q=0, Q_valid=0, Par_err=0, Busy=1, boot counter=0, state=INIT. Memory contents are not cleared by reset itself.
- State machine with states INIT and IDLE.
- INIT:
  - Each cycle, writes boot_word(cnt) to mem[cnt], then cnt+1.
  - When cnt==DEPTH-1 has been written: go to IDLE and drop Busy on the next edge. Total INIT duration is DEPTH cycles after reset release.
  - Rd_en, Wren and Init_req are ignored; Q_valid stays 0 and Q holds its value.
- IDLE:
  - Busy=0.
  - Init_req=1 resets cnt to 0, enters INIT and sets Busy=1 on the next edge. Init_req has priority over Rd_en/Wren in the same cycle: both are dropped.
- Fetch:
  - Rd_en=1 in IDLE: Q<=mem[Rd_addr] and Q_valid<=1 on the same edge, so latency is 1 cycle.
  - Q_valid deasserts the cycle after; Q holds its last value.
  - Back-to-back reads are allowed at one per cycle.
- Load:
  - Wren=1 in IDLE: mem[Wr_addr]<=Din.
  - Wren does not change Q unless a read is issued in the same cycle.
- Simultaneous read and write:
  - Same address: write-through; Q<=Din and the memory is updated.
  - Different addresses: both are performed independently.
- Boot image (16-bit encoding: op[15:13], fields below):
  - Opcodes: NOP=0, ADD=2, SUB=3, LD=4, ST=5. Registers R0..R3 are 3-bit codes.
  - addr0 = 0xA081 (ST R0,R1,#1)
  - addr1 = 0x8882 (LD R2,R1,#2)
  - addr2 = 0x40A0 (ADD R0,R1,R2)
  - addr3 = 0x60A2 (SUB R0,R1,R2,#2)
  - addr4 = 0x6000 (SUB R0,R0,R0)
  - addr5 = 0x40A0
  - addr6 = 0x40A0
  - All others = 0.
- Boot counter is ADDR_W+1 bits wide; no wrap-around occurs inside INIT.
- Reset asserted mid-INIT restarts INIT from cnt=0. Partially written words are overwritten by the restart.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from the write data (boot word or Din).
  - Extra input Flip_par (1 bit): when high together with Wren, the stored parity bit is inverted (error injection).
  - On each fetch, Par_err<=(^Q_data != stored parity), registered and aligned with Q_valid; Par_err=0 when Q_valid=0.
  - Write-through reads compute parity from Din, including the Flip_par effect.
- Undefined: no parity storage, no Flip_par port, Par_err tied to 0.

Decomposition:
- Shared package imem_pkg holds: opcode constants, register codes, the state encoding (INIT/IDLE), and the boot image as a function boot_word(addr) returning a 16-bit word.
- One sub-module is natural: imem_boot_seq (counter + FSM producing Busy, the write address and the write-enable muxed into the array).
- Storage array and fetch/load logic stay in the top module.

Test Plan:
- Reset pulse low 2 cycles, then release → Busy=1 for 16 cycles, then 0. Reads of addr0..6 return 0xA081, 0x8882, 0x40A0, 0x60A2, 0x6000, 0x40A0, 0x40A0 with Q_valid one cycle after each Rd_en. addr7..15 return 0.
- Rd_en on addr3 during INIT → Q_valid stays 0 and Q unchanged. After Busy falls, Wren addr9 Din=0x1234 then Rd_en addr9 → Q=0x1234 one cycle later.
- Same-cycle Wren and Rd_en on addr2 with Din=0xBEEF → Q=0xBEEF next cycle, and a subsequent read of addr2 returns 0xBEEF.
- Overwrite addr0 with 0xFFFF, then pulse Init_req → Busy high for 16 cycles, then addr0 reads 0xA081. Init_req together with Wren to addr5 → addr5 still holds 0x40A0.
- Reset asserted at INIT cycle 5 → outputs clear immediately, and INIT runs a full 16 cycles from addr0.
- With IMEM_PARITY_EN: write addr4 with Flip_par=1, then read it → Par_err=1 with Q_valid. A normal write/read → Par_err=0.
